uart_tx_frame: RTL
==================

Name: uart_tx_frame

Overview:
- Complete, parametrised UART transmitter: FSM, baud divider, data shift register, parity generator and registered line driver in one block.
- Generalises the fixed 8-bit TX controller:
  - configurable data width, stop-bit count and baud divisor;
  - runtime-selectable even/odd parity;
  - valid/ready input handshake;
  - back-to-back frames with no idle gap.
- Sits between the host-side byte source and the serial TX pin.

Parameters:
- DATA_W, 8, data bits per frame; legal range 5..9; sent LSB first.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- BAUD_DIV, 16, clk cycles per serial bit; minimum 2.
- CNT_W, $clog2(BAUD_DIV), baud counter width; derived, not overridden.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- ARSTn, input, 1, asynchronous active-low reset.
- tx_data, input, DATA_W, parallel word to transmit.
- data_valid, input, 1, tx_data/par_en/par_odd are valid.
- in_ready, output, 1, block can accept a word this cycle.
- par_en, input, 1, append a parity bit to this frame.
- par_odd, input, 1, parity type when par_en=1: 0 = even, 1 = odd.
- tx_out, output, 1, serial line; idle high; registered.
- busy, output, 1, a frame is in progress.
- frame_done, output, 1, one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (ARSTn low, asynchronous): state IDLE, tx_out=1, busy=0, in_ready=1, frame_done=0, all counters and shift register cleared.
- Handshake:
  - Word is accepted in a cycle where data_valid && in_ready.
  - On acceptance, tx_data, par_en and par_odd are latched. Later input changes do not affect the frame in flight.
  - in_ready = (state==IDLE) || (state==STOP && last stop bit && baud_cnt==BAUD_DIV-1).
  - data_valid while in_ready=0 is ignored (not queued); the source holds it until accepted.
- Baud timing:
  - baud_cnt counts 0..BAUD_DIV-1 in every non-IDLE state.
  - bit_end = (baud_cnt==BAUD_DIV-1). Each serial bit is exactly BAUD_DIV cycles.
  - baud_cnt is cleared on acceptance.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_out=1, busy=0. On acceptance -> START.
  - START: tx_out=0. On bit_end -> DATA, bit_idx=0.
  - DATA: tx_out = shift_reg[0]. On bit_end: shift right, bit_idx++. When bit_idx==DATA_W-1 at bit_end -> PARITY if latched par_en, else STOP.
  - PARITY: tx_out = ^data_latched ^ par_odd. On bit_end -> STOP, stop_idx=0.
  - STOP: tx_out=1. On bit_end:
    - if stop_idx < STOP_BITS-1: stop_idx++ and remain in STOP;
    - else pulse frame_done; -> START if a new word is accepted this cycle, otherwise -> IDLE.
- Latency: acceptance in cycle N -> tx_out falls at N+1 (registered output). tx_out is glitch-free and changes only on bit boundaries.
- busy = 1 from the cycle after acceptance through the last stop-bit cycle; 0 in IDLE. Stays high across back-to-back frames.
- Frame length = (1 + DATA_W + par_en + STOP_BITS) * BAUD_DIV cycles.
- Back-to-back frames: the next start bit begins in the cycle immediately after the final stop-bit cycle. Zero idle cycles; busy does not drop.
- Reset mid-frame: immediate return to reset values, tx_out high; the partial frame is abandoned.
- Illegal state encodings recover to IDLE with outputs at IDLE values.

Test Plan:
- Basic frame, no parity: DATA_W=8, BAUD_DIV=4, STOP_BITS=1, tx_data=8'hA5, par_en=0.
  - tx_out per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1.
  - 40 cycles total; frame_done pulses once on cycle 40; busy then 0.
- Parity, both types: tx_data=8'h07 (three ones), par_en=1.
  - par_odd=0 -> parity bit 1.
  - par_odd=1 -> parity bit 0.
  - Frame is 11 bits = 44 cycles.
- Back-to-back: hold data_valid=1 with 8'h55 then 8'h0F.
  - in_ready high only in the last stop-bit cycle.
  - Second start bit immediately follows the stop bit; busy stays 1 throughout; two frame_done pulses exactly 40 cycles apart.
- Input change during frame: change tx_data and par_en in mid-DATA.
  - Transmitted bits and parity still match the latched values.
  - data_valid raised mid-frame is ignored until in_ready=1.
- Wide and two-stop configuration: DATA_W=9, STOP_BITS=2, BAUD_DIV=2, tx_data=9'h1C3.
  - LSB first; two high stop bits; frame is 12 bits = 24 cycles.
- Mid-frame reset: assert ARSTn low during DATA bit 3.
  - tx_out=1, busy=0, in_ready=1 immediately.
  - A word accepted after release transmits a clean full frame.

Source files
------------

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// Parametrised UART transmitter. Accepts a parallel word over a valid/ready
// handshake and serialises it as:
//   start bit (0), DATA_W data bits LSB first, optional parity bit,
//   STOP_BITS stop bits (1).
// Every serial bit lasts exactly BAUD_DIV clock cycles. A new word can be
// accepted in the final cycle of the last stop bit, so back-to-back frames
// run with no idle gap and busy stays high between them.
//
// Parameters:
//   DATA_W     data bits per frame (5..9)
//   STOP_BITS  stop bits per frame (1 or 2)
//   BAUD_DIV   clk cycles per serial bit (>= 2)
//   CNT_W      baud counter width; derived from BAUD_DIV, leave at default
//
// Ports:
//   clk         system clock, rising edge
//   ARSTn       asynchronous active-low reset
//   tx_data     parallel word to transmit
//   data_valid  tx_data / par_en / par_odd are valid
//   in_ready    a word offered this cycle will be accepted
//   par_en      append a parity bit to this frame
//   par_odd     parity type when par_en=1 (0 = even, 1 = odd)
//   tx_out      registered serial line, idle high
//   busy        a frame is in progress
//   frame_done  one-cycle pulse during the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int BAUD_DIV  = 16,
    parameter int CNT_W     = $clog2(BAUD_DIV)
) (
    input  logic              clk,
    input  logic              ARSTn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              data_valid,
    output logic              in_ready,
    input  logic              par_en,
    input  logic              par_odd,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    state_e            state_q,    state_d;
    logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]  bit_idx_q,  bit_idx_d;
    logic              stop_idx_q, stop_idx_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic              par_en_q,   par_en_d;
    logic              par_bit_q,  par_bit_d;
    logic              tx_out_q,   tx_out_d;

    logic bit_end;
    logic last_data;
    logic last_stop;
    logic last_stop_end;
    logic accept;

    // -------------------------------------------------------------------------
    // Bit-boundary decode, taken straight from the registered state so the
    // handshake and frame_done never depend on the incoming data_valid.
    // -------------------------------------------------------------------------
    assign bit_end       = (baud_cnt_q == CNT_W'(BAUD_DIV - 1));
    assign last_data     = (bit_idx_q == IDX_W'(DATA_W - 1));
    assign last_stop     = (stop_idx_q == 1'(STOP_BITS - 1));
    assign last_stop_end = (state_q == ST_STOP) && last_stop && bit_end;

    // Ready in IDLE, and also in the very last cycle of a frame so the next
    // start bit can follow the stop bit with zero idle cycles.
    assign in_ready   = (state_q == ST_IDLE) || last_stop_end;
    assign accept     = data_valid && in_ready;
    assign frame_done = last_stop_end;

    // Only legal active states report busy; an illegal encoding looks idle
    // for the single cycle it takes to recover.
    assign busy = (state_q inside {ST_START, ST_DATA, ST_PARITY, ST_STOP});

    assign tx_out = tx_out_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch; without it a
        // path that leaves a signal unassigned would infer a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;

        // Free-running bit timer in every active state, wrapping each bit.
        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // Leaves only through acceptance below.
            end

            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (last_data) begin
                        state_d    = par_en_q ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end

            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                end
            end

            ST_STOP: begin
                if (bit_end) begin
                    if (!last_stop) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                // Illegal encoding: drop back to a clean idle.
                state_d    = ST_IDLE;
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                stop_idx_d = 1'b0;
            end
        endcase

        // Acceptance from IDLE or from the final stop-bit cycle. The word and
        // its parity are captured here so later input changes cannot disturb
        // the frame in flight. Parity is computed now because the shift
        // register no longer holds the full word by the time it is sent.
        if (accept) begin
            state_d    = ST_START;
            baud_cnt_d = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            shift_d    = tx_data;
            par_en_d   = par_en;
            par_bit_d  = (^tx_data) ^ par_odd;
        end
    end

    // The line level is computed from the state being entered so the
    // registered pin lines up with that state: the start bit appears the
    // cycle after acceptance and the pin only moves on bit boundaries.
    always_comb begin
        tx_out_d = 1'b1;
        case (state_d)
            ST_START:  tx_out_d = 1'b0;
            ST_DATA:   tx_out_d = shift_d[0];
            ST_PARITY: tx_out_d = par_bit_d;
            default:   tx_out_d = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_out_q   <= tx_out_d;
        end
    end

endmodule
